// File: rtl/tick_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen_multi
//  Description : NCH independent programmable tick generators (pulse or
//                square wave) with shadowed divide values and global restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen_multi #(
    parameter int NCH     = 4,
    parameter int CW      = 32,
    parameter int DIV_RST = 100_000_000
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NCH-1:0]                          en,
    input  logic [NCH-1:0]                          mode,
    input  logic                                    sync,
    input  logic                                    div_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] div_sel,
    input  logic [CW-1:0]                           div_data,
    output logic [NCH-1:0]                          tick
);

    localparam int            c_sw      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] c_div_rst = CW'(DIV_RST);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [c_sw-1:0] c_idx = c_sw'(i);

        logic [CW-1:0] r_act;
        logic [CW-1:0] r_shd;
        logic [CW-1:0] r_cnt;
        logic          r_pnd;
        logic          r_tick;

        logic          w_wr;
        logic          w_tc;
        logic [CW-1:0] w_dm1;
        logic [CW-1:0] w_next_act;

        // Selects beyond NCH-1 never match any channel index, so they are dropped.
        assign w_wr       = div_we && (div_sel == c_idx);
        assign w_dm1      = (r_act == '0) ? '0 : r_act - CW'(1);
        assign w_tc       = en[i] && (r_cnt == w_dm1);
        // A write landing on a reload edge wins over an older pending value.
        assign w_next_act = w_wr ? div_data : (r_pnd ? r_shd : r_act);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act  <= c_div_rst;
                r_shd  <= c_div_rst;
                r_cnt  <= '0;
                r_pnd  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_shd <= div_data;
                end
                if (sync || !en[i]) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_act  <= w_next_act;
                    r_pnd  <= 1'b0;
                end else if (w_tc) begin
                    r_cnt  <= '0;
                    r_tick <= mode[i] ? ~r_tick : 1'b1;
                    r_act  <= w_next_act;
                    r_pnd  <= 1'b0;
                end else begin
                    r_cnt  <= r_cnt + CW'(1);
                    r_tick <= mode[i] & r_tick;
                    if (w_wr) begin
                        r_pnd <= 1'b1;
                    end
                end
            end
        end

        assign tick[i] = r_tick;
    end

endmodule
`default_nettype wire
